// File: rtl/msfsm_sched_pkg.sv
// Shared constants for the MSFSM firing scheduler: default sizing,
// FSM state encodings and the index-width helper.
// Pure declarations; no logic, no latency, no flow control.
package msfsm_sched_pkg;

  localparam int NT_DEF            = 7;
  localparam int SETTLE_CYCLES_DEF = 1;
  localparam int DL_LIMIT_DEF      = 16;
  localparam int CW_DEF            = 16;

  // Scheduler FSM encoding, kept as plain constants so legacy tools that
  // dislike enums in port-adjacent logic still read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FIRE   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  // Width of a transition index; never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msfsm_rr_pick.sv
// Round-robin picker: first set bit of cand at or above ptr, wrapping to bit 0.
// Purely combinational, zero latency.
// No flow control; caller qualifies the result with any.
module msfsm_rr_pick
  import msfsm_sched_pkg::*;
#(
  parameter int NT = NT_DEF
) (
  input  logic [NT-1:0]        cand,
  input  logic [idx_w(NT)-1:0] ptr,
  output logic                 any,
  output logic [idx_w(NT)-1:0] sel
);

  localparam int IW = idx_w(NT);

  logic [2*NT-1:0] dbl;
  logic [2*NT-1:0] masked;
  int              pos;

  // Duplicate the candidate vector so the wrap becomes a plain upward scan:
  // mask off everything below ptr in the low copy, then take the lowest
  // remaining bit. The high copy supplies the wrapped-around candidates.
  always_comb begin
    dbl    = {cand, cand};
    masked = '0;
    pos    = 0;
    for (int i = 0; i < 2*NT; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2*NT-1; i >= 0; i--) begin
      if (masked[i]) begin
        pos = i;
      end
    end
    any = |cand;
    sel = (pos >= NT) ? IW'(pos - NT) : IW'(pos);
  end

endmodule

// File: rtl/msfsm_fire_scheduler.sv
// Grants one-hot transition fires round-robin among requested and enabled transitions.
// Latency: candidate seen in IDLE at cycle n -> fire high in cycle n+1; one grant per 2+SETTLE_CYCLES.
// Backpressure: en low holds IDLE; inputs are ignored outside IDLE and a grant is never revoked.
module msfsm_fire_scheduler
  import msfsm_sched_pkg::*;
#(
  parameter int NT            = NT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DL_LIMIT      = DL_LIMIT_DEF,
  parameter int CW            = CW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NT-1:0]        req,
  input  logic [NT-1:0]        enabled,
  input  logic                 clr_deadlock,
  output logic [NT-1:0]        fire,
  output logic [idx_w(NT)-1:0] fire_idx,
  output logic                 busy,
  output logic                 deadlock,
  output logic [CW-1:0]        fire_count
);

  localparam int              IW          = idx_w(NT);
  localparam int              SW          = $clog2(DL_LIMIT + 1);
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [SW-1:0]   DL_MAX      = SW'(DL_LIMIT);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(NT - 1);

  state_t          state_q, state_d;
  logic [NT-1:0]   fire_q, fire_d;
  logic [IW-1:0]   fire_idx_q, fire_idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sc_q, sc_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            dl_q, dl_d;

  logic [NT-1:0]   cand;
  logic            pick_any;
  logic [IW-1:0]   pick_sel;
  logic            blocked;

  assign cand = req & enabled;

  msfsm_rr_pick #(
    .NT (NT)
  ) u_pick (
    .cand (cand),
    .ptr  (ptr_q),
    .any  (pick_any),
    .sel  (pick_sel)
  );

  // Grant FSM: sample in IDLE, hold the one-hot pulse for exactly one cycle,
  // then let the MSFSM outputs settle before looking at requests again.
  always_comb begin
    state_d    = state_q;
    fire_d     = '0;
    fire_idx_d = fire_idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    sc_d       = sc_q;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          fire_d     = NT'(1) << pick_sel;
          fire_idx_d = pick_sel;
          state_d    = ST_FIRE;
        end
      end
      ST_FIRE: begin
        // Pointer and count only advance once the pulse has actually been
        // driven for a full cycle, so a reset during FIRE leaves no trace.
        ptr_d = (fire_idx_q == LAST_IDX) ? '0 : fire_idx_q + IW'(1);
        cnt_d = cnt_q + CW'(1);
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
          sc_d    = SETTLE_INIT;
        end
      end
      ST_SETTLE: begin
        if (sc_q <= 4'd1) begin
          state_d = ST_IDLE;
          sc_d    = '0;
        end else begin
          sc_d = sc_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall detection: count consecutive IDLE cycles where something is
  // requested but nothing requested is enabled; a clear always dominates.
  always_comb begin
    blocked = (state_q == ST_IDLE) && en && (req != '0) && (cand == '0);
    stall_d = stall_q;
    dl_d    = dl_q;
    if (blocked) begin
      if (stall_q < DL_MAX) begin
        stall_d = stall_q + SW'(1);
      end
      if (stall_d == DL_MAX) begin
        dl_d = 1'b1;
      end
    end else begin
      stall_d = '0;
    end
    if (clr_deadlock) begin
      stall_d = '0;
      dl_d    = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fire_q     <= '0;
      fire_idx_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      sc_q       <= '0;
      stall_q    <= '0;
      dl_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fire_q     <= fire_d;
      fire_idx_q <= fire_idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      sc_q       <= sc_d;
      stall_q    <= stall_d;
      dl_q       <= dl_d;
    end
  end

  assign fire       = fire_q;
  assign fire_idx   = fire_idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign deadlock   = dl_q;
  assign fire_count = cnt_q;

endmodule

// File: tb/tb_msfsm_fire_scheduler.sv
// Bench for msfsm_fire_scheduler: expected grants are queued as stimulus is
// applied and popped by a monitor when fire is observed. A second instance with
// a 2-bit counter shares every input to exercise counter wrap.
module tb_msfsm_fire_scheduler;

  localparam int NT = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0;
  logic            clr_deadlock = 1'b0;
  logic [NT-1:0]   req = '0;
  logic [NT-1:0]   enabled = '0;

  logic [NT-1:0]   fire, fire_b;
  logic [2:0]      fire_idx, fire_idx_b;
  logic            busy, busy_b, deadlock, deadlock_b;
  logic [15:0]     fire_count;
  logic [1:0]      fire_count_b;

  msfsm_fire_scheduler #(.NT(NT), .SETTLE_CYCLES(1), .DL_LIMIT(16), .CW(16)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .enabled(enabled),
    .clr_deadlock(clr_deadlock), .fire(fire), .fire_idx(fire_idx), .busy(busy),
    .deadlock(deadlock), .fire_count(fire_count)
  );

  msfsm_fire_scheduler #(.NT(NT), .SETTLE_CYCLES(1), .DL_LIMIT(16), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .req(req), .enabled(enabled),
    .clr_deadlock(clr_deadlock), .fire(fire_b), .fire_idx(fire_idx_b), .busy(busy_b),
    .deadlock(deadlock_b), .fire_count(fire_count_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   exp_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, expv, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int at_cyc);
    exp_t e;
    e.idx = idx;
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    en      = 1'b0;
    req     = '0;
    enabled = '0;
    tick();
    reset   = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    tick();
  endtask

  // Monitor: every cycle out of reset at most one fire bit; any fire must
  // match the head of the expectation queue in vector, index, cycle and count.
  always @(negedge clk) begin
    if (reset) begin
      check("onehot0", 32'($onehot0(fire)), 1);
      if (fire != '0) begin
        check("busy_in_fire", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_fire", fire, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("fire_vec", fire, 32'(1) << mon_e.idx);
          check("fire_idx", fire_idx, mon_e.idx);
          check("fire_cycle", cyc, mon_e.cyc);
          check("count_at_fire", fire_count, exp_cnt);
          check("fire_vec_b", fire_b, 32'(1) << mon_e.idx);
          check("count_b_at_fire", fire_count_b, exp_cnt % 4);
          exp_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then reset during FIRE
    tick(2);
    check("rst_fire", fire, 0);
    check("rst_idx", fire_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_deadlock", deadlock, 0);
    check("rst_count", fire_count, 0);
    reset = 1'b1;
    tick(4);
    check("idle_fire", fire, 0);
    check("idle_busy", busy, 0);
    check("idle_count", fire_count, 0);

    en = 1'b1; req = 7'b0000001; enabled = 7'b0000001;
    c = cyc;
    push(0, c + 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0; en = 1'b0; req = '0; enabled = '0;
    #1;
    check("midfire_fire", fire, 0);
    check("midfire_busy", busy, 0);
    check("midfire_count", fire_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_cnt = 0;
    tick(2);
    check("post_reset_count", fire_count, 0);

    // 2: two candidates, pointer at 0
    en = 1'b1; req = 7'b0000011; enabled = 7'b0000011;
    c = cyc;
    push(0, c + 1);
    push(1, c + 4);
    tick(4);
    req = '0; enabled = '0;
    drain();
    tick(2);
    check("t2_count", fire_count, 2);

    // 3: all eligible from a fresh pointer: t0..t6 then t0
    do_reset();
    en = 1'b1; req = 7'h7F; enabled = 7'h7F;
    c = cyc;
    for (int k = 0; k < 8; k++) push(k % NT, c + 1 + 3 * k);
    tick(22);
    req = '0; enabled = '0;
    drain();
    tick(3);
    check("t3_count", fire_count, 8);
    check("t3_count_b_wrap", fire_count_b, 0);

    // 4: deadlock threshold, sticky flag, clear, clear-wins, then release
    en = 1'b1; req = 7'b0000100; enabled = '0;
    tick(15);
    check("dl_before_limit", deadlock, 0);
    tick(1);
    check("dl_at_limit", deadlock, 1);
    tick(3);
    check("dl_sticky", deadlock, 1);
    clr_deadlock = 1'b1;
    tick(1);
    clr_deadlock = 1'b0;
    check("dl_cleared", deadlock, 0);
    tick(15);
    check("dl_recount", deadlock, 0);
    clr_deadlock = 1'b1;
    tick(1);
    clr_deadlock = 1'b0;
    check("dl_clear_wins", deadlock, 0);
    enabled = 7'b0000100;
    c = cyc;
    push(2, c + 1);
    drain();
    req = '0; enabled = '0;
    tick(2);

    // 5: en gating, and en dropping during FIRE
    en = 1'b0; req = 7'h7F; enabled = 7'h7F;
    tick(6);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_count", fire_count, 9);
    en = 1'b1;
    c = cyc;
    push(3, c + 1);
    tick(1);
    en = 1'b0;
    check("t5_busy_fire", busy, 1);
    tick(1);
    check("t5_busy_settle", busy, 1);
    tick(8);
    drain();
    check("t5_end_busy", busy, 0);
    check("t5_count", fire_count, 10);
    req = '0; enabled = '0;

    // 6: request change during SETTLE is picked up only back in IDLE
    do_reset();
    en = 1'b1; enabled = 7'h7F; req = 7'b0000001;
    c = cyc;
    push(0, c + 1);
    tick(2);
    req = 7'b1000000;
    push(6, c + 4);
    tick(2);
    req = '0;
    drain();
    tick(3);
    check("t6_count", fire_count, 2);

    // 6b: 2-bit counter wraps to zero after four fires
    do_reset();
    en = 1'b1; req = 7'h7F; enabled = 7'h7F;
    c = cyc;
    for (int k = 0; k < 4; k++) push(k, c + 1 + 3 * k);
    tick(10);
    req = '0; enabled = '0;
    drain();
    tick(3);
    check("wrap_count", fire_count, 4);
    check("wrap_count_b", fire_count_b, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msfsm_fire_scheduler.md
Name: msfsm_fire_scheduler

Overview:
- Firing controller for the synchronised Mealy MSFSM network.
- Collects per-transition firing requests and combines them with per-transition enable status. Each transition's enable is the AND of the state-synchronisation outputs of every FSM in its preset.
- Issues exactly one one-hot transition-fire pulse at a time, round-robin among eligible transitions, so conflicting (free-choice) transitions never fire together.
- Holds firing off until the FSM outputs settle; flags suspected deadlock.

Parameters:
- NT, 7, number of transitions (t0..t(NT-1)); min 2.
- SETTLE_CYCLES, 1, idle cycles after each fire before the next grant; range 0..15.
- DL_LIMIT, 16, consecutive blocked cycles before deadlock is flagged; min 1.
- CW, 16, width of the fire counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  scheduler enable; grants are issued only while high.
- req  in  NT  firing requests, level-sensitive, bit i = ti.
- enabled  in  NT  transition enable status from the MSFSM sync outputs, bit i = ti.
- clr_deadlock  in  1  synchronous clear of the deadlock flag.
- fire  out  NT  one-hot fire pulse; drives the MSFSM t inputs; registered.
- fire_idx  out  $clog2(NT)  index of the current or last fired transition.
- busy  out  1  high in the FIRE and SETTLE states.
- deadlock  out  1  sticky deadlock flag.
- fire_count  out  CW  total number of fires.

Behaviour:
- Reset (reset=0, async), all outputs and state cleared: fire=0, fire_idx=0, busy=0, deadlock=0, fire_count=0, rr pointer=0, stall counter=0, state=IDLE.
- States:
  - IDLE: cand = req & enabled. If en=1 and cand≠0, select the first set bit of cand at or after ptr, scanning upward and wrapping NT-1→0. Register fire=onehot(sel) and fire_idx=sel. Go to FIRE.
  - FIRE: lasts exactly 1 cycle; fire is high only in this cycle. ptr←(sel+1) mod NT. fire_count+1, wrapping 2^CW-1→0. Go to SETTLE with sc=SETTLE_CYCLES; if SETTLE_CYCLES=0, go directly to IDLE.
  - SETTLE: fire=0. sc decrements each cycle; go to IDLE when sc reaches 1, so SETTLE lasts SETTLE_CYCLES cycles.
- Latency: cand≠0 sampled in IDLE at cycle n → fire high during cycle n+1.
- Grant period: with continuous eligibility, one grant every 2+SETTLE_CYCLES cycles.
- At most one fire bit is ever set. fire is never asserted outside FIRE.
- req/enabled are sampled only in IDLE. Changes during FIRE/SETTLE are ignored; no grant is revoked.
- en=0 in IDLE: no grant. en dropping during FIRE/SETTLE: the sequence completes, then the block holds in IDLE.
- Stall counter:
  - Increments in IDLE when en=1, req≠0 and cand=0.
  - Clears when cand≠0, req=0, en=0, or the state leaves IDLE.
  - Saturates at DL_LIMIT. On reaching DL_LIMIT, deadlock←1 (sticky).
- clr_deadlock=1 clears deadlock and the stall counter. If it coincides with the threshold being reached, the clear wins.
- Deadlock does not inhibit scheduling.
- Reset asserted mid-FIRE: fire drops immediately (async). No partial count.

Decomposition:
- Package msfsm_sched_pkg:
  - state enum {IDLE, FIRE, SETTLE} (2 bits);
  - default NT, DL_LIMIT, SETTLE_CYCLES constants;
  - function idx_w(NT)=$clog2(NT).
- One sub-module msfsm_rr_pick: combinational round-robin pick. Inputs: cand[NT], ptr. Outputs: any, sel index. Implemented with a double-width masked priority encode.
- FSM, counters and flag stay in the top block.

Test Plan (NT=7, SETTLE_CYCLES=1, DL_LIMIT=16):
1. Reset, then idle inputs → fire=0, busy=0, deadlock=0, fire_count=0. Pulse reset low mid-FIRE → fire=0 the same cycle; fire_count is not incremented.
2. req=enabled=7'b0000011, en=1, ptr=0 → fire=7'b0000001 (fire_idx=0) one cycle after sampling. Next grant is fire=7'b0000010, 3 cycles after the first. fire_count=2.
3. req=enabled=7'h7F held → grants t0,t1,…,t6,t0, one every 3 cycles. Never two fire bits set. fire_count=8 after 8 grants.
4. req=7'b0000100, enabled=0, en=1 → deadlock=1 after exactly 16 IDLE cycles. clr_deadlock=1 → deadlock=0 next cycle. Raise enabled[2]=1 → fire=7'b0000100.
5. en=0 with req=enabled=7'h7F → no fire. Set en=1, then drop en in the FIRE cycle → that single fire completes, SETTLE runs, then no further fire.
6. req changes during SETTLE (req=7'b1000000 after t0 fired) → ignored until IDLE, then fire=7'b1000000. Counter wrap check with CW=2: after 4 fires, fire_count=0.
